// File: rtl/jk_seq_pkg.sv
// Shared types and constants for the JK command sequencer.
// The abort/flush feature is enabled with the JK_SEQ_ABORT_EN macro.
package jk_seq_pkg;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } seq_state_e;

    localparam logic [1:0] JK_00 = 2'b00;
    localparam logic [1:0] JK_01 = 2'b01;
    localparam logic [1:0] JK_10 = 2'b10;
    localparam logic [1:0] JK_11 = 2'b11;

    localparam logic [1:0] JK_IDLE_DEFAULT = JK_10;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers and an occupancy count.
// The flush_i port exists only when JK_SEQ_ABORT_EN is defined.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef JK_SEQ_ABORT_EN
    input  logic                     flush_i,
`endif
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;
    logic             flush;

`ifdef JK_SEQ_ABORT_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // No pass-through: a push is refused whenever the FIFO is full, even if
    // a pop happens on the same edge.
    assign push_ok = push_i && !full_o && !flush;
    assign pop_ok  = pop_i && !empty_o && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// Buffers {J,K} commands and plays each onto registered J/K for cmd_len+1 cycles.
// Define JK_SEQ_ABORT_EN to add the abort input (flush + force idle).
module jk_cmd_seq
    import jk_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 4,
    parameter logic [1:0]  IDLE_JK = JK_IDLE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_jk,
    input  logic [CNT_W-1:0]         cmd_len,
    output logic                     J,
    output logic                     K,
    output logic                     busy,
    output logic                     done,
`ifdef JK_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned WIDTH = 2 + CNT_W;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        jk_q, jk_d;
    logic              done_q, done_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  fifo_data;
    logic              push;
    logic              pop;
    logic              abort_w;

`ifdef JK_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready && !abort_w;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef JK_SEQ_ABORT_EN
        .flush_i (abort),
`endif
        .push_i  (push),
        .data_i  ({cmd_jk, cmd_len}),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        jk_d    = jk_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                jk_d = IDLE_JK;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    jk_d    = fifo_data[CNT_W +: 2];
                    rem_d   = fifo_data[CNT_W-1:0];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end else begin
                    // Last cycle: chain straight into the next command if one waits.
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        jk_d  = fifo_data[CNT_W +: 2];
                        rem_d = fifo_data[CNT_W-1:0];
                    end else begin
                        jk_d    = IDLE_JK;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                jk_d    = IDLE_JK;
                state_d = S_IDLE;
            end
        endcase
        if (abort_w) begin
            pop     = 1'b0;
            done_d  = 1'b0;
            jk_d    = IDLE_JK;
            rem_d   = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            jk_q    <= IDLE_JK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            jk_q    <= jk_d;
            done_q  <= done_d;
        end
    end

    assign J    = jk_q[1];
    assign K    = jk_q[0];
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Command sequencer that sits directly upstream of the team's JK flip-flop and generates its J and K inputs. It accepts {J,K} commands with a hold length over a valid/ready handshake and buffers them in a small FIFO. It then plays each command onto registered J/K outputs for a programmable number of cycles. Gaps between commands drive a fixed idle code.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- CNT_W, 4: width of the length field
- IDLE_JK, 2'b10: {J,K} value driven when no command is active
- Clk  input  1  clock; all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_jk  input  2  {J,K} code to drive, passed verbatim
- cmd_len  input  CNT_W  hold length minus one; the command drives for cmd_len+1 cycles
- J  output  1  registered J to the flip-flop
- K  output  1  registered K to the flip-flop
- busy  output  1  high while a command is being driven
- done  output  1  one-cycle pulse at the end of each command
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- abort  input  1  present only with JK_SEQ_ABORT_EN

## Operation
- Reset state: {J,K}=IDLE_JK, busy=0, done=0, level=0, FSM=IDLE, FIFO empty. cmd_ready=1 while reset is asserted.
- Handshake: a command is accepted on a posedge with cmd_valid&&cmd_ready. The source holds cmd_jk and cmd_len stable while valid and not ready. cmd_valid with ready low is ignored.
- FIFO: pointer width $clog2(DEPTH)+1 with wrap bit. Full when pointers are equal except the MSB; empty when fully equal.
  - No pass-through when full, so a push is never accepted while full.
  - A push and a pop in the same cycle leave level unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and load {J,K}=cmd_jk and rem=cmd_len, set busy=1, and go to RUN. Otherwise drive IDLE_JK.
  - RUN with rem≠0: rem decrements and {J,K} holds.
  - RUN with rem==0 (last cycle): pulse done on the next edge. If the FIFO is non-empty, pop and load the next command on that same edge, with no idle gap. Otherwise go to IDLE with {J,K}=IDLE_JK and busy=0.
- Arithmetic: rem is CNT_W bits and only decrements; it never wraps. cmd_len = 2^CNT_W−1 gives 2^CNT_W cycles.
- Reset mid-operation: return immediately and asynchronously to the reset state. The FIFO contents are discarded.

## Timing
- Accept at edge E0 into an empty FIFO while IDLE: the pop occurs in the following cycle, and J/K show cmd_jk from edge E1. Latency is 1 cycle.
- A command occupies edges E1..E(cmd_len+1). The next command, or IDLE_JK, appears at E(cmd_len+2).
- done is high for exactly the cycle following E(cmd_len+1), i.e. it is registered at E(cmd_len+2).
- level updates on the accepting or popping edge. cmd_ready is combinational from registered state only, with no path from cmd_valid.

## Configuration
- JK_SEQ_ABORT_EN defined: the abort input exists.
  - abort high at a posedge flushes the FIFO (level→0), forces FSM=IDLE, {J,K}=IDLE_JK, busy=0, and done=0.
  - abort takes priority over a simultaneous push; that push is dropped even if cmd_ready was high.
- JK_SEQ_ABORT_EN undefined: no abort port and no flush logic. Commands always run to completion.

## Structure
- Package jk_seq_pkg holds:
  - FSM state enum {S_IDLE, S_RUN}
  - code constants JK_00, JK_01, JK_10, JK_11
  - the default idle code
- Sub-module jk_cmd_fifo (DEPTH, WIDTH=2+CNT_W): synchronous FIFO with push, pop, full, empty and level. jk_cmd_seq instantiates it and adds the FSM and output registers.

## Test plan
- Reset: assert rst_n=0 mid-RUN with 3 entries queued → J,K=1,0, busy=0, level=0, cmd_ready=1 asynchronously.
- Single command: push jk=11, len=2 into an idle block at E0 → J=K=1 on E1–E3, IDLE_JK from E4, done high for 1 cycle after E3.
- Back-to-back: push jk=01 len=0 then jk=00 len=1 consecutively → J,K = 01 for 1 cycle then 00 for 2 cycles, no idle gap, two done pulses.
- Full: DEPTH=4 with the FSM running a long command, push 4 → cmd_ready=0, level=4; a fifth valid is held and accepted only on the cycle after the first pop.
- Max length: CNT_W=4, len=15 → J/K held exactly 16 cycles.
- Abort (macro on): abort during RUN with 2 queued plus a simultaneous push → next edge IDLE_JK, level=0, the pushed command never appears.
